// File: rtl/timer_counter_if.sv
// timer_counter_if
//   Word-addressed load/store bus between the system bridge and the timer.
//   The bridge (master) drives the address, write strobe, byte enables and
//   write data. The timer (slave) returns combinational read data and its
//   interrupt request.
//
//   addr    [1:0]  word offset: 0=CTRL, 1=PRESET, 2=COUNT, 3=unused
//   we             write strobe, asserted only when the timer is selected
//   byteen  [3:0]  per-byte write enable for wdata
//   wdata   [31:0] write data
//   rdata   [31:0] read data for the current addr
//   irq            interrupt request from the timer
interface timer_counter_if;
    logic [1:0]  addr;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (
        output addr,
        output we,
        output byteen,
        output wdata,
        input  rdata,
        input  irq
    );

    modport slave (
        input  addr,
        input  we,
        input  byteen,
        input  wdata,
        output rdata,
        output irq
    );
endinterface

// File: rtl/timer_counter.sv
// timer_counter
//   Memory-mapped programmable down-counter timer on the data-memory side of
//   the system bridge. Software programs PRESET and CTRL; the counter loads
//   PRESET, counts down to zero and raises an interrupt flag. One-shot mode
//   holds the flag until software writes CTRL or PRESET and clears EN.
//   Auto-reload mode produces a one-cycle flag pulse every PRESET+3 cycles.
//
//   clk    system clock, all state updates on the rising edge
//   reset  synchronous, active-high reset
//   bus    timer_counter_if.slave (addr, we, byteen, wdata, rdata, irq)
//
//   CTRL layout: [0] EN, [2:1] MODE (01 auto-reload, else one-shot),
//                [3] IM interrupt mask; upper bits read as zero.
module timer_counter #(
    parameter int COUNT_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    timer_counter_if.slave  bus
);

    localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CNT,
        ST_INT
    } state_t;

    state_t               state;
    logic [3:0]           ctrl_q;
    logic [COUNT_W-1:0]   preset_q;
    logic [COUNT_W-1:0]   count_q;
    logic                 irq_flag;

    logic [3:0]           ctrl_wr;
    logic [31:0]          preset_cur;
    logic [31:0]          preset_merged;
    logic [COUNT_W-1:0]   preset_wr;
    logic                 auto_reload;
    logic                 wr_ctrl;
    logic                 wr_preset;

    // Byte-masked write values. CTRL only stores its low nibble, so only
    // byte lane 0 can change it. PRESET is merged at full bus width and then
    // truncated, which discards any bits above COUNT_W.
    always_comb begin
        ctrl_wr       = bus.byteen[0] ? bus.wdata[3:0] : ctrl_q;
        preset_cur    = 32'(preset_q);
        preset_merged = preset_cur;
        for (int i = 0; i < 4; i++) begin
            if (bus.byteen[i]) begin
                preset_merged[8*i +: 8] = bus.wdata[8*i +: 8];
            end
        end
        preset_wr = preset_merged[COUNT_W-1:0];
    end

    assign auto_reload = (ctrl_q[2:1] == 2'b01);
    assign wr_ctrl     = bus.we && (bus.addr == 2'd0);
    assign wr_preset   = bus.we && (bus.addr == 2'd1);

    // Counter FSM plus software register writes in one process. The software
    // write assignments come after the FSM case so that, on a shared edge, a
    // CTRL write overrides the one-shot EN clear and a CTRL/PRESET write's
    // flag clear overrides a flag set from the count expiring.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            irq_flag <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctrl_q[0]) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    count_q <= preset_q;
                    state   <= ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl_q[0]) begin
                        state <= ST_IDLE;
                    end else if (count_q > COUNT_ONE) begin
                        count_q <= count_q - COUNT_ONE;
                    end else begin
                        // Clamping at <=1 makes PRESET=0 behave like PRESET=1
                        // and keeps the count from wrapping.
                        count_q  <= '0;
                        irq_flag <= 1'b1;
                        state    <= ST_INT;
                    end
                end
                ST_INT: begin
                    if (auto_reload) begin
                        irq_flag <= 1'b0;
                    end else begin
                        ctrl_q[0] <= 1'b0;
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (wr_ctrl) begin
                ctrl_q   <= ctrl_wr;
                irq_flag <= 1'b0;
            end
            if (wr_preset) begin
                preset_q <= preset_wr;
                irq_flag <= 1'b0;
            end
        end
    end

    // Read mux: side-effect free, registers zero-extended to the bus width.
    always_comb begin
        bus.rdata = '0;
        case (bus.addr)
            2'd0:    bus.rdata = {28'd0, ctrl_q};
            2'd1:    bus.rdata = 32'(preset_q);
            2'd2:    bus.rdata = 32'(count_q);
            default: bus.rdata = '0;
        endcase
    end

    assign bus.irq = irq_flag & ctrl_q[3];

endmodule
